// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional two's-complement
// mode, Go/Busy/Done handshake and divide-by-zero reporting.
module seq_divider #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Go,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIXUP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_sr;   // dividend magnitude in, quotient magnitude out
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] rem;
  logic             neg_dvd;
  logic             neg_dvs;
  logic             zero;

  logic             in_neg_dvd;
  logic             in_neg_dvs;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    in_neg_dvd = (SIGNED != 0) && Dividend[WIDTH-1];
    in_neg_dvs = (SIGNED != 0) && Divisor[WIDTH-1];
    // -(-2^(W-1)) wraps to 2^(W-1), which is still the correct unsigned magnitude
    in_dvd_mag = in_neg_dvd ? -Dividend : Dividend;
    in_dvs_mag = in_neg_dvs ? -Divisor : Divisor;

    trial = {rem, dvd_sr[WIDTH-1]};
    fits  = trial >= {1'b0, dvs_mag};
    diff  = trial[WIDTH-1:0] - dvs_mag;

    if (zero) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end else begin
      q_fix = (neg_dvd ^ neg_dvs) ? -dvd_sr : dvd_sr;
      r_fix = neg_dvd ? -rem : rem;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_sr    <= '0;
      dvs_mag   <= '0;
      dvd_raw   <= '0;
      rem       <= '0;
      neg_dvd   <= 1'b0;
      neg_dvs   <= 1'b0;
      zero      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            dvd_sr  <= in_dvd_mag;
            dvs_mag <= in_dvs_mag;
            dvd_raw <= Dividend;
            neg_dvd <= in_neg_dvd;
            neg_dvs <= in_neg_dvs;
            zero    <= (Divisor == '0);
            rem     <= '0;
            cnt     <= CW'(WIDTH);
            Busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rem    <= fits ? diff : trial[WIDTH-1:0];
          dvd_sr <= {dvd_sr[WIDTH-2:0], fits};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          Quotient  <= q_fix;
          Remainder <= r_fix;
          DivByZero <= zero;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: four instances (4/8-bit, unsigned/signed) driven with
// directed vectors; a negedge monitor pops expected results whenever Done pulses.
module tb_seq_divider;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    int unsigned cyc;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [3:0]  go = '0;
  logic [3:0]  busy, done, dbz;
  logic [3:0]  a0 = '0, b0 = '0, q0, r0;
  logic [3:0]  a1 = '0, b1 = '0, q1, r1;
  logic [7:0]  a2 = '0, b2 = '0, q2, r2;
  logic [7:0]  a3 = '0, b3 = '0, q3, r3;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          dcnt0 = 0;
  logic [16:0] held2 = '0;
  exp_t        sb0[$], sb1[$], sb2[$], sb3[$];

  seq_divider #(.WIDTH(4), .SIGNED(0)) u_u4 (
    .Clock(Clock), .Resetn(Resetn), .Go(go[0]), .Dividend(a0), .Divisor(b0),
    .Quotient(q0), .Remainder(r0), .Busy(busy[0]), .Done(done[0]), .DivByZero(dbz[0]));
  seq_divider #(.WIDTH(4), .SIGNED(1)) u_s4 (
    .Clock(Clock), .Resetn(Resetn), .Go(go[1]), .Dividend(a1), .Divisor(b1),
    .Quotient(q1), .Remainder(r1), .Busy(busy[1]), .Done(done[1]), .DivByZero(dbz[1]));
  seq_divider #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .Clock(Clock), .Resetn(Resetn), .Go(go[2]), .Dividend(a2), .Divisor(b2),
    .Quotient(q2), .Remainder(r2), .Busy(busy[2]), .Done(done[2]), .DivByZero(dbz[2]));
  seq_divider #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .Clock(Clock), .Resetn(Resetn), .Go(go[3]), .Dividend(a3), .Divisor(b3),
    .Quotient(q3), .Remainder(r3), .Busy(busy[3]), .Done(done[3]), .DivByZero(dbz[3]));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int unsigned wid(input int id);
    return (id < 2) ? 4 : 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input exp_t e);
    case (id)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      2: sb2.push_back(e);
      default: sb3.push_back(e);
    endcase
  endtask

  task automatic check_done(input int id, input logic [7:0] q, input logic [7:0] r,
                            input logic z);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (id)
      0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
      1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
      2: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
      default: if (sb3.size() > 0) begin e = sb3.pop_front(); have = 1'b1; end
    endcase
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL unexpected_done id=%0d: got Done with q=0x%0h r=0x%0h required no Done",
               id, q, r);
    end else begin
      chk($sformatf("quotient id%0d", id), q, e.q);
      chk($sformatf("remainder id%0d", id), r, e.r);
      chk($sformatf("divbyzero id%0d", id), z, e.dbz);
      chk($sformatf("done_cycle id%0d", id), cyc, e.cyc);
    end
  endtask

  always @(negedge Clock) begin
    if (!Resetn) held2 = '0;
    if (done[0]) begin dcnt0++; check_done(0, {4'b0, q0}, {4'b0, r0}, dbz[0]); end
    if (done[1]) check_done(1, {4'b0, q1}, {4'b0, r1}, dbz[1]);
    if (done[2]) begin
      check_done(2, q2, r2, dbz[2]);
      held2 = {q2, r2, dbz[2]};
    end
    if (done[3]) check_done(3, q3, r3, dbz[3]);
    // results must stay frozen while the next transaction is shifting
    if (busy[2] && Resetn) chk("hold_u8", {q2, r2, dbz[2]}, held2);
  end

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ed,
                       input bit do_push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge Clock);
    while (busy[id] && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (busy[id]) begin
      chk($sformatf("idle_timeout id%0d", id), busy[id], 1'b0);
    end else begin
      case (id)
        0: begin a0 = a[3:0]; b0 = b[3:0]; end
        1: begin a1 = a[3:0]; b1 = b[3:0]; end
        2: begin a2 = a; b2 = b; end
        default: begin a3 = a; b3 = b; end
      endcase
      go[id] = 1'b1;
      if (do_push) begin
        e.q = eq; e.r = er; e.dbz = ed;
        e.cyc = cyc + 1 + wid(id) + 1;
        push(id, e);
      end
      @(negedge Clock);
      go[id] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() + sb1.size() + sb2.size() + sb3.size()) != 0 && n < 80) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_pending", sb0.size() + sb1.size() + sb2.size() + sb3.size(), 0);
  endtask

  initial begin
    exp_t        e;
    int unsigned c0;
    int          d;
    logic [7:0]  x, y;

    repeat (2) @(negedge Clock);
    chk("rst_q", {q0, q1, q2, q3}, 0);
    chk("rst_r", {r0, r1, r2, r3}, 0);
    chk("rst_flags", {busy, done, dbz}, 0);
    Resetn = 1'b1;

    // 4-bit unsigned
    issue(0, 8'd13, 8'd3,  8'd4,  8'd1, 1'b0, 1'b1);
    issue(0, 8'd9,  8'd0,  8'd15, 8'd9, 1'b1, 1'b1);
    issue(0, 8'd15, 8'd1,  8'd15, 8'd0, 1'b0, 1'b1);
    issue(0, 8'd2,  8'd7,  8'd0,  8'd2, 1'b0, 1'b1);
    issue(0, 8'd15, 8'd15, 8'd1,  8'd0, 1'b0, 1'b1);
    // 4-bit signed (low nibble is the operand)
    issue(1, 8'h09, 8'h00, 8'h0F, 8'h09, 1'b1, 1'b1);  // -7/0
    issue(1, 8'h08, 8'h0F, 8'h08, 8'h00, 1'b0, 1'b1);  // -8/-1
    issue(1, 8'h07, 8'h0E, 8'h0D, 8'h01, 1'b0, 1'b1);  // 7/-2
    issue(1, 8'h08, 8'h03, 8'h0E, 8'h0E, 1'b0, 1'b1);  // -8/3
    // 8-bit unsigned directed
    issue(2, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b1);
    issue(2, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b1);
    issue(2, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b1);
    issue(2, 8'd1,   8'd200, 8'd0,   8'd1,   1'b0, 1'b1);
    issue(2, 8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      x = 8'(i * 37 + 5);
      y = 8'(i * 13 + 1);
      issue(2, x, y, x / y, x % y, 1'b0, 1'b1);
    end
    // 8-bit signed
    issue(3, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b1);  // -7/2
    issue(3, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1);  // 7/-2
    issue(3, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);  // -128/-1
    issue(3, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1);  // -128/1
    issue(3, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b1);  // 100/-7
    issue(3, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b1);  // -100/7
    issue(3, 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b1);  // -5/0

    // Go pulsed while busy must be ignored
    issue(0, 8'd14, 8'd4, 8'd3, 8'd2, 1'b0, 1'b1);
    @(negedge Clock);
    a0 = 4'd1; b0 = 4'd1; go[0] = 1'b1;
    @(negedge Clock);
    go[0] = 1'b0;
    drain();

    // Go held high: accepts every WIDTH+2 edges, operands changed mid-shift
    @(negedge Clock);
    a2 = 8'd50; b2 = 8'd7; go[2] = 1'b1;
    c0 = cyc;
    e.q = 8'd7; e.r = 8'd1; e.dbz = 1'b0; e.cyc = c0 + 1 + 9; push(2, e);
    repeat (3) @(negedge Clock);
    a2 = 8'd200; b2 = 8'd9;
    e.q = 8'd22; e.r = 8'd2; e.dbz = 1'b0; e.cyc = c0 + 11 + 9; push(2, e);
    repeat (10) @(negedge Clock);
    a2 = 8'd90; b2 = 8'd0;
    e.q = 8'hFF; e.r = 8'd90; e.dbz = 1'b1; e.cyc = c0 + 21 + 9; push(2, e);
    repeat (8) @(negedge Clock);
    go[2] = 1'b0;
    drain();

    // asynchronous reset mid-shift: outputs clear at once, no Done afterwards
    issue(0, 8'd13, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_q0r0", {q0, r0}, 0);
    chk("midrst_flags0", {busy[0], done[0], dbz[0]}, 0);
    chk("midrst_u8_outputs", {q2, r2, dbz[2]}, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    d = dcnt0;
    repeat (8) @(negedge Clock);
    chk("no_done_after_reset", dcnt0, d);
    chk("idle_after_reset", busy[0], 1'b0);

    // first edge after release accepts a new transaction
    issue(0, 8'd7, 8'd2, 8'd3, 8'd1, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider that generalises the lab's single-cycle 4-bit divide to any operand width, with optional signed mode, a Go/Busy/Done handshake and divide-by-zero reporting. It accepts one operand pair per transaction, produces one quotient bit per clock, and holds its registered results until the next transaction completes. It sits beside the lab's other arithmetic blocks, driven from switches or a control FSM.

## Interface
- WIDTH, 4: operand and result width in bits; legal range ≥ 2.
- SIGNED, 0: 0 = unsigned division; 1 = two's-complement division.
- Clock  input  1  system clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Go  input  1  start request; sampled only in IDLE.
- Dividend  input  WIDTH  numerator; sampled on the accepting edge only.
- Divisor  input  WIDTH  denominator; sampled on the accepting edge only.
- Quotient  output  WIDTH  registered quotient.
- Remainder  output  WIDTH  registered remainder.
- Busy  output  1  high while a transaction is in progress.
- Done  output  1  one-cycle pulse; results are valid in this cycle.
- DivByZero  output  1  registered with results; high if the captured Divisor was 0.

## Operation
- States are IDLE, SHIFT and FIXUP.
- **IDLE, Go=1 edge:**
  - Capture the dividend and divisor magnitudes. In signed mode, take the absolute value and store both sign bits; otherwise use the raw values.
  - Clear the partial remainder, load the step counter with WIDTH, and set a zero flag if Divisor==0.
  - Busy goes to 1 and the state moves to SHIFT.
- **IDLE, Go=0:** no change; outputs hold.
- **SHIFT, each edge:**
  - Form {partial remainder, MSB of dividend shift register} as a WIDTH+1-bit value.
  - Subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When the counter reaches 1 on this edge, the next state is FIXUP.
  - The internal datapath is WIDTH+1 bits wide; no truncation occurs before FIXUP.
- **FIXUP edge, unsigned mode:** load the Quotient and Remainder registers with the magnitude results.
- **FIXUP edge, signed mode:**
  - Negate the quotient if the two operand signs differ.
  - Negate the remainder if the dividend was negative. Rounding is toward zero, and the remainder sign follows the dividend.
- **FIXUP edge, divide by zero:** overrides both modes. Quotient becomes all ones and Remainder becomes the captured raw Dividend.
- **FIXUP edge, signed overflow (−2^(WIDTH−1) / −1):** Quotient = −2^(WIDTH−1) (wraps) and Remainder = 0. This is not flagged.
- **FIXUP edge, common to all cases:** DivByZero is loaded, Done=1, Busy=0, and the state returns to IDLE.
- **Go while Busy=1:** ignored; no queueing.
- **Operand changes after acceptance:** no effect on the transaction in flight.

## Timing
- **Reset (asynchronous assertion):** state=IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0, and internal registers are cleared.
- **Reset mid-transaction:** aborts the transaction with no Done pulse.
- **Reset release:** the first active edge after release may accept Go.
- **Latency** (accepting edge = edge 0):
  - Busy is high after edges 0 through WIDTH.
  - Results, DivByZero and Done update at edge WIDTH+1.
  - Done is high for exactly one cycle, between edges WIDTH+1 and WIDTH+2.
  - Latency is fixed at WIDTH+1 edges regardless of operands, divide-by-zero included.
- **Back-to-back transactions:** Go high during the Done cycle is accepted at edge WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- **Outputs:** Quotient, Remainder and DivByZero hold their values from one Done to the next. They do not change during SHIFT.
- **Glitch-free outputs:** Busy and Done come straight from registers.

## Test plan
- **Reset:** WIDTH=4. Assert Resetn=0 asynchronously mid-SHIFT → all outputs 0 immediately, and no Done follows release.
- **Basic unsigned division:** WIDTH=4, SIGNED=0, Dividend=13, Divisor=3, one-cycle Go → Busy for 5 cycles, then Done pulse with Quotient=4, Remainder=1, DivByZero=0, exactly 5 edges after acceptance.
- **Width sweep:** WIDTH=8 unsigned, exhaustive or random sweep against a reference model → all results match the `/` and `%` operators; latency is 9 edges.
- **Divide by zero:**
  - WIDTH=4 unsigned, Dividend=9, Divisor=0 → Quotient=15, Remainder=9, DivByZero=1.
  - WIDTH=4 signed, Dividend=−7 → Quotient=−1, Remainder=−7, DivByZero=1.
- **Signed mode:** WIDTH=8, SIGNED=1.
  - −7/2 → Quotient=−3, Remainder=−1.
  - 7/−2 → Quotient=−3, Remainder=1.
  - −128/−1 → Quotient=−128, Remainder=0.
- **Handshake:**
  - Pulse Go again while Busy → ignored; the result belongs to the first operands.
  - Hold Go high continuously and change operands during SHIFT → consecutive Done pulses every WIDTH+2 cycles, each reflecting the operands present on its accepting edge.
